// File: rtl/fifo_ptr_cntr_if.sv
// Bundle of request, control and status signals between the pointer counter and its user.
// Gray-coded pointer members exist only when FIFO_GRAY_PTR_EN is defined.
interface fifo_ptr_cntr_if #(
  parameter int AW = 3
);
  logic          wr_en;
  logic          rd_en;
  logic          flush;
  logic          err_clr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          afull;
  logic          aempty;
  logic          ovf;
  logic          udf;
`ifdef FIFO_GRAY_PTR_EN
  logic [AW-1:0] wr_ptr_gray;
  logic [AW-1:0] rd_ptr_gray;
`endif

  modport master (
    output wr_en, rd_en, flush, err_clr,
    input  wr_ptr, rd_ptr, level, full, empty, afull, aempty, ovf, udf
`ifdef FIFO_GRAY_PTR_EN
    , input wr_ptr_gray, rd_ptr_gray
`endif
  );

  modport slave (
    input  wr_en, rd_en, flush, err_clr,
    output wr_ptr, rd_ptr, level, full, empty, afull, aempty, ovf, udf
`ifdef FIFO_GRAY_PTR_EN
    , output wr_ptr_gray, rd_ptr_gray
`endif
  );
endinterface

// File: rtl/fifo_ptr_cntr.sv
// Write/read pointers, fill level and registered flow-control flags for a 2**AW deep FIFO.
// Define FIFO_GRAY_PTR_EN to add registered Gray-coded copies of both pointers.
module fifo_ptr_cntr #(
  parameter int AW     = 3,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  fifo_ptr_cntr_if.slave   io_fifo
);
  localparam int            DEPTH_I = 1 << AW;
  localparam logic [AW:0]   DEPTH   = DEPTH_I[AW:0];
  localparam logic [AW:0]   AF_THR  = AF_LVL[AW:0];
  localparam logic [AW:0]   AE_THR  = AE_LVL[AW:0];
  localparam logic [AW:0]   LVL_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic          AF_RST  = (AF_LVL == 0);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_full;
  logic          r_empty;
  logic          r_afull;
  logic          r_aempty;
  logic          r_ovf;
  logic          r_udf;

  logic          w_rd_acc;
  logic          w_wr_acc;
  logic [AW-1:0] w_wr_ptr_next;
  logic [AW-1:0] w_rd_ptr_next;
  logic [AW:0]   w_level_next;
  logic          w_ovf_next;
  logic          w_udf_next;

  // A write into a full FIFO only goes through when a read frees a slot in the same cycle.
  assign w_rd_acc = io_fifo.rd_en & ~r_empty;
  assign w_wr_acc = io_fifo.wr_en & (~r_full | w_rd_acc);

  always_comb begin
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_level_next  = r_level;
    w_ovf_next    = r_ovf;
    w_udf_next    = r_udf;
    if (io_fifo.err_clr) begin
      w_ovf_next = 1'b0;
      w_udf_next = 1'b0;
    end
    if (io_fifo.flush) begin
      w_wr_ptr_next = '0;
      w_rd_ptr_next = '0;
      w_level_next  = '0;
    end else begin
      if (w_wr_acc) w_wr_ptr_next = r_wr_ptr + PTR_ONE;
      if (w_rd_acc) w_rd_ptr_next = r_rd_ptr + PTR_ONE;
      if (w_wr_acc && !w_rd_acc) w_level_next = r_level + LVL_ONE;
      else if (w_rd_acc && !w_wr_acc) w_level_next = r_level - LVL_ONE;
      // Setting an error takes priority over a simultaneous clear.
      if (io_fifo.wr_en && !w_wr_acc) w_ovf_next = 1'b1;
      if (io_fifo.rd_en && !w_rd_acc) w_udf_next = 1'b1;
    end
  end

  // Flags are derived from the next level so they line up with the new LEVEL value.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= AF_RST;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_level  <= w_level_next;
      r_full   <= (w_level_next == DEPTH);
      r_empty  <= (w_level_next == '0);
      r_afull  <= (w_level_next >= AF_THR);
      r_aempty <= (w_level_next <= AE_THR);
      r_ovf    <= w_ovf_next;
      r_udf    <= w_udf_next;
    end
  end

  assign io_fifo.wr_ptr = r_wr_ptr;
  assign io_fifo.rd_ptr = r_rd_ptr;
  assign io_fifo.level  = r_level;
  assign io_fifo.full   = r_full;
  assign io_fifo.empty  = r_empty;
  assign io_fifo.afull  = r_afull;
  assign io_fifo.aempty = r_aempty;
  assign io_fifo.ovf    = r_ovf;
  assign io_fifo.udf    = r_udf;

`ifdef FIFO_GRAY_PTR_EN
  logic [AW-1:0] r_wr_gray;
  logic [AW-1:0] r_rd_gray;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_gray <= '0;
      r_rd_gray <= '0;
    end else begin
      r_wr_gray <= w_wr_ptr_next ^ (w_wr_ptr_next >> 1);
      r_rd_gray <= w_rd_ptr_next ^ (w_rd_ptr_next >> 1);
    end
  end

  assign io_fifo.wr_ptr_gray = r_wr_gray;
  assign io_fifo.rd_ptr_gray = r_rd_gray;
`endif
endmodule
